// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : mips_pkg
//  Purpose  : Shared encodings for the multiply/divide unit.
//             Covers the op codes and the FSM state type.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

  // Operation encodings carried on the op port
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // True for the two divide operations
  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the two signed operations
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface : mul_div_unit_if
//  Purpose   : Command/result bundle between control unit and the MDU.
//  Revision  : 1.0  initial release
// ============================================================================
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Control unit side
  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo,
    input  busy, done, hi, lo
  );

  // Multiply/divide unit side
  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_step
//  Purpose  : One radix-2 iteration of the multiply (shift-add) or
//             divide (restoring shift-subtract) datapath.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [2*WIDTH-1:0] acc,       // {upper, lower} accumulator
  input  wire logic [WIDTH-1:0]   operand,   // multiplicand or divisor magnitude
  input  wire logic               is_div,
  output logic      [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;      // multiply partial sum with carry
  logic [WIDTH:0]   partial;  // remainder shifted left with next dividend bit
  logic             fits;     // divisor fits into the shifted remainder
  logic [WIDTH-1:0] rem_sub;  // remainder after a successful subtract

  // Single-iteration next-accumulator for both modes
  always_comb begin
    // Multiply: add multiplicand when LSB of multiplier is set, then shift right
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Divide: shift {rem, dividend} left by one, try to subtract divisor.
    // The difference is always below the divisor, so WIDTH bits hold it.
    partial  = acc[2*WIDTH-1:WIDTH-1];
    fits     = (partial >= {1'b0, operand});
    rem_sub  = partial[WIDTH-1:0] - operand;
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (fits) begin
        acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative MIPS multiply/divide unit owning HI/LO.
//             MULT/MULTU/DIV/DIVU in WIDTH+1 cycles, plus MTHI/MTLO writes.
//  Revision : 1.0  initial release
// ============================================================================
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mul_div_unit_if.slave  bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t                 state;
  state_t                 state_next;
  logic [CW-1:0]          count;
  logic [1:0]             op_reg;
  logic                   sign_q;      // product / quotient negated
  logic                   sign_r;      // remainder negated (dividend sign)
  logic                   div_zero;
  logic [WIDTH-1:0]       dividend;    // raw rs for the divide-by-zero result
  logic [WIDTH-1:0]       operand;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     acc_next;
  logic [WIDTH-1:0]       hi_reg;
  logic [WIDTH-1:0]       lo_reg;
  logic                   done_reg;

  logic                   launch;
  logic                   new_div;
  logic                   new_sgn;
  logic                   neg_a;
  logic                   neg_b;
  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       fix_hi;
  logic [WIDTH-1:0]       fix_lo;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand),
    .is_div   (op_is_div(op_reg)),
    .acc_next (acc_next)
  );

  assign launch    = (state == S_IDLE) && bus.start;
  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = done_reg;
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;

  // Operand magnitudes and sign decode for a new operation
  always_comb begin
    new_div = op_is_div(bus.op);
    new_sgn = op_is_signed(bus.op);
    neg_a   = new_sgn & bus.rs_data[WIDTH-1];
    neg_b   = new_sgn & bus.rt_data[WIDTH-1];
    mag_a   = neg_a ? (-bus.rs_data) : bus.rs_data;
    mag_b   = neg_b ? (-bus.rt_data) : bus.rt_data;
  end

  // Final sign correction and divide-by-zero override
  always_comb begin
    prod   = sign_q ? (-acc) : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_is_div(op_reg)) begin
      if (div_zero) begin
        fix_lo = {WIDTH{1'b1}};
        fix_hi = dividend;
      end else begin
        fix_lo = sign_q ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        fix_hi = sign_r ? (-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start)    state_next = S_CALC;
      S_CALC:  if (count == LAST) state_next = S_FIX;
      S_FIX:                     state_next = S_IDLE;
      default:                   state_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, result write and MT path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      op_reg   <= MD_MULT;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      dividend <= '0;
      operand  <= '0;
      acc      <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            op_reg   <= bus.op;
            count    <= '0;
            sign_q   <= neg_a ^ neg_b;
            sign_r   <= neg_a;
            div_zero <= (bus.rt_data == '0);
            dividend <= bus.rs_data;
            if (new_div) begin
              acc     <= {{WIDTH{1'b0}}, mag_a};
              operand <= mag_b;
            end else begin
              acc     <= {{WIDTH{1'b0}}, mag_b};
              operand <= mag_a;
            end
          end else begin
            if (bus.mthi) hi_reg <= bus.rs_data;
            if (bus.mtlo) lo_reg <= bus.rs_data;
          end
        end
        S_CALC: begin
          acc   <= acc_next;
          count <= count + 1'b1;
        end
        S_FIX: begin
          hi_reg   <= fix_hi;
          lo_reg   <= fix_lo;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
